i2c_line_conditioner: RTL and testbench

//  Front end for the I2C slave datapath: synchronises raw scl/sda pad inputs to clk and rejects glitches.

---
 rtl/i2c_pkg.sv | 16 +
 rtl/i2c_glitch_filter.sv | 64 ++++++
 rtl/i2c_line_conditioner.sv | 89 ++++++++
 tb/tb_i2c_line_conditioner.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared constants for the I2C slave front end, the slave byte engine and the bench.
package i2c_pkg;

  localparam int   I2C_FILT_LEN_DEF = 4;        // 80 ns at 50 MHz
  localparam int   I2C_TIMEOUT_DEF  = 1750000;  // 35 ms at 50 MHz
  localparam int   I2C_TO_W_DEF     = 21;
  localparam logic I2C_IDLE_LVL     = 1'b1;

  // One conditioned line: settled level plus its one-cycle edge strobes.
  typedef struct packed {
    logic level;
    logic rise;
    logic fall;
  } line_t;

endpackage

// File: rtl/i2c_glitch_filter.sv
// Two-flop synchroniser plus stability counter for one open-drain line;
// the level only moves after FILT_LEN consecutive cycles of disagreement.
module i2c_glitch_filter
  import i2c_pkg::*;
#(
  parameter int FILT_LEN = I2C_FILT_LEN_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic             s1_q, s2_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  // NOTE: sequential state uses <= so every flop samples pre-edge values; blocking here would collapse the sync pair.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q    <= I2C_IDLE_LVL;
      s2_q    <= I2C_IDLE_LVL;
      level_q <= I2C_IDLE_LVL;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      s1_q    <= raw;
      s2_q    <= s1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // NOTE: every always_comb output is defaulted first so no path leaves it unassigned (no latch).
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (s2_q != level_q) begin
      if (cnt_q == CNT_W'(FILT_LEN - 1)) begin
        level_d = s2_q;
        rise_d  = s2_q;
        fall_d  = ~s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/i2c_line_conditioner.sv
// I2C pad front end: filtered SCL/SDA, edge strobes, START/STOP decode,
// bus-busy tracking and SCL-stuck-low timeout.
module i2c_line_conditioner
  import i2c_pkg::*;
#(
  parameter int FILT_LEN    = I2C_FILT_LEN_DEF,
  parameter int TIMEOUT_CYC = I2C_TIMEOUT_DEF,
  parameter int TO_W        = I2C_TO_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_f,
  output logic sda_f,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic bus_busy,
  output logic timeout
);

  line_t scl_l, sda_l;

  i2c_glitch_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
    .clk   (clk),
    .reset (reset),
    .raw   (scl_in),
    .level (scl_l.level),
    .rise  (scl_l.rise),
    .fall  (scl_l.fall)
  );

  i2c_glitch_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
    .clk   (clk),
    .reset (reset),
    .raw   (sda_in),
    .level (sda_l.level),
    .rise  (sda_l.rise),
    .fall  (sda_l.fall)
  );

  logic            scl_steady;
  logic            start_c, stop_c, timeout_c;
  logic            busy_q, busy_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  // Decode is a pure AND of flop outputs, so strobes line up with the level
  // update and nothing combinational reaches an output from a pad.
  // An SDA move in the same cycle as an SCL move is a hold violation, not START/STOP.
  assign scl_steady = ~(scl_l.rise | scl_l.fall);
  assign start_c    = sda_l.fall & scl_l.level & scl_steady;
  assign stop_c     = sda_l.rise & scl_l.level & scl_steady;
  assign timeout_c  = busy_q & ~scl_l.level & (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q   <= 1'b0;
      to_cnt_q <= '0;
    end else begin
      busy_q   <= busy_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  always_comb begin
    busy_d   = busy_q;
    to_cnt_d = '0;
    if (start_c) begin
      busy_d = 1'b1;
    end else if (stop_c || timeout_c) begin
      busy_d = 1'b0;
    end
    if (busy_q && !scl_l.level && !timeout_c) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  assign scl_f     = scl_l.level;
  assign sda_f     = sda_l.level;
  assign scl_rise  = scl_l.rise;
  assign scl_fall  = scl_l.fall;
  assign start_det = start_c;
  assign stop_det  = stop_c;
  assign bus_busy  = busy_q;
  assign timeout   = timeout_c;

endmodule

// File: tb/tb_i2c_line_conditioner.sv
// Directed bench for i2c_line_conditioner: reset, glitch rejection, byte transfer,
// repeated START, SCL-low timeout and simultaneous-edge handling.
module tb_i2c_line_conditioner;
  import i2c_pkg::*;

  localparam int H      = 20;   // SCL half-period in clk cycles
  localparam int TO_CYC = 100;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic scl_in = 1'b0;
  logic sda_in = 1'b0;
  logic scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det, bus_busy, timeout;

  always #5 clk = ~clk;

  i2c_line_conditioner #(
    .FILT_LEN    (I2C_FILT_LEN_DEF),
    .TIMEOUT_CYC (TO_CYC),
    .TO_W        (I2C_TO_W_DEF)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .scl_f     (scl_f),
    .sda_f     (sda_f),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .bus_busy  (bus_busy),
    .timeout   (timeout)
  );

  int checks = 0;
  int errors = 0;
  int n_rise = 0, n_fall = 0, n_start = 0, n_stop = 0, n_to = 0;
  int busy_low = 0;
  logic [7:0] rx_byte = 8'h00;

  // Strobe counters sampled 1 ns after each rising edge.
  always begin
    @(posedge clk);
    #1;
    if (!reset) begin
      if (scl_rise) begin
        n_rise++;
        rx_byte = {rx_byte[6:0], sda_f};
      end
      if (scl_fall)  n_fall++;
      if (start_det) n_start++;
      if (stop_det)  n_stop++;
      if (timeout)   n_to++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      if (!bus_busy) busy_low++;
    end
  endtask

  task automatic i2c_start();
    sda_in = 1'b0; tick(H);
    scl_in = 1'b0; tick(H);
  endtask

  task automatic send_bit(input logic b);
    sda_in = b;    tick(H);
    scl_in = 1'b1; tick(H);
    scl_in = 1'b0; tick(H);
  endtask

  task automatic i2c_rstart();
    sda_in = 1'b1; tick(H);
    scl_in = 1'b1; tick(H);
    sda_in = 1'b0; tick(H);
    scl_in = 1'b0; tick(H);
  endtask

  task automatic i2c_stop();
    sda_in = 1'b0; tick(H);
    scl_in = 1'b1; tick(H);
    sda_in = 1'b1; tick(H);
  endtask

  initial begin
    int s_rise, s_fall, s_start, s_stop, s_to, n;
    logic seen, found;
    logic [7:0] fall_seen;
    logic [7:0] tx_byte;
    logic [8:0] tx9;

    // 1. Reset with both pads low: outputs must show an idle bus.
    repeat (3) begin
      @(negedge clk);
      check("rst_scl_f", scl_f, 1);
      check("rst_sda_f", sda_f, 1);
      check("rst_busy", bus_busy, 0);
      check("rst_strobes", {scl_rise, scl_fall, start_det, stop_det, timeout}, 0);
    end
    reset = 1'b0;
    tick(12);
    check("post_rst_low", {scl_f, sda_f}, 2'b00);
    scl_in = 1'b1; sda_in = 1'b1;
    tick(12);
    check("post_rst_idle", {scl_f, sda_f, bus_busy}, 3'b110);
    check("post_rst_no_ss", n_start + n_stop, 0);

    // 2. Glitch rejection: 3-cycle spike is dropped, 4-cycle spike passes.
    s_fall = n_fall;
    seen = 1'b0;
    scl_in = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 3) scl_in = 1'b1;
      seen |= scl_fall | ~scl_f;
    end
    check("glitch3_blocked", seen, 0);
    check("glitch3_no_fall", n_fall - s_fall, 0);

    fall_seen = '0;
    scl_in = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 4) scl_in = 1'b1;
      fall_seen[k-1] = scl_fall;
    end
    check("glitch4_fall_at_6", fall_seen, 8'h20);
    tick(12);
    check("glitch4_recover", scl_f, 1);
    check("glitch_no_ss", {start_det, stop_det, bus_busy}, 0);

    // 3. START, byte 0xA5, STOP.
    s_start = n_start; s_stop = n_stop;
    i2c_start();
    check("byte_busy_set", bus_busy, 1);
    check("byte_start_cnt", n_start - s_start, 1);
    s_rise = n_rise; s_fall = n_fall; busy_low = 0;
    tx_byte = 8'hA5;
    for (int i = 7; i >= 0; i--) send_bit(tx_byte[i]);
    check("byte_rise_cnt", n_rise - s_rise, 8);
    check("byte_fall_cnt", n_fall - s_fall, 8);
    check("byte_rx", rx_byte, 8'hA5);
    check("byte_busy_held", busy_low, 0);
    check("byte_no_stop", n_stop - s_stop, 0);
    i2c_stop();
    check("byte_stop_cnt", n_stop - s_stop, 1);
    check("byte_start_total", n_start - s_start, 1);
    check("byte_busy_clr", bus_busy, 0);

    // 4. Repeated START: busy must hold across it.
    s_start = n_start; s_stop = n_stop;
    i2c_start();
    busy_low = 0;
    tx9 = 9'h14A;
    for (int i = 8; i >= 0; i--) send_bit(tx9[i]);
    i2c_rstart();
    check("rs_start_cnt", n_start - s_start, 2);
    check("rs_busy_held", busy_low, 0);
    check("rs_no_stop", n_stop - s_stop, 0);
    i2c_stop();
    check("rs_stop_cnt", n_stop - s_stop, 1);
    check("rs_busy_clr", bus_busy, 0);

    // 5. Timeout: START, then SCL held low.
    sda_in = 1'b0; tick(H);
    check("to_busy_set", bus_busy, 1);
    scl_in = 1'b0;
    n = 0; found = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      @(negedge clk);
      if (scl_fall) n = 1;
      else if (n > 0) n++;
      if (timeout) found = 1'b1;
    end
    check("to_found", found, 1);
    check("to_cycle", n, TO_CYC);
    @(negedge clk);
    check("to_busy_clr", bus_busy, 0);
    check("to_one_cycle", timeout, 0);
    s_to = n_to;
    tick(150);
    scl_in = 1'b1; tick(H);
    check("to_no_repeat", n_to - s_to, 0);
    s_stop = n_stop;
    sda_in = 1'b1; tick(H);
    check("to_orphan_stop", n_stop - s_stop, 1);
    check("to_orphan_busy", bus_busy, 0);

    // 6. SCL and SDA move in the same cycle: edges only, no START/STOP.
    s_start = n_start; s_stop = n_stop; s_fall = n_fall; s_rise = n_rise;
    scl_in = 1'b0; sda_in = 1'b0; tick(H);
    check("sim_fall", n_fall - s_fall, 1);
    check("sim_no_start", n_start - s_start, 0);
    scl_in = 1'b1; sda_in = 1'b1; tick(H);
    check("sim_rise", n_rise - s_rise, 1);
    check("sim_no_stop", n_stop - s_stop, 0);
    check("sim_busy", bus_busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
